// File: rtl/io_bank_cfg_reg.sv
// N-channel bidirectional IO bank for edge tiles: per-channel output/tristate modes,
// pad-input synchroniser with rising-edge detect, frame-configured mode register.
module io_bank_cfg_reg #(
  parameter int NUM_CH          = 4,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int CFG_FRAME       = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       UserCLK,
  input  logic                       UserRST,
  input  logic [NUM_CH-1:0]          I,
  input  logic [NUM_CH-1:0]          T,
  output logic [NUM_CH-1:0]          O,
  output logic [NUM_CH-1:0]          Q,
  output logic [NUM_CH-1:0]          E,
  output logic [NUM_CH-1:0]          I_top,
  output logic [NUM_CH-1:0]          T_top,
  input  logic [NUM_CH-1:0]          O_top,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

  localparam int CW = 4 * NUM_CH;

  generate
    if ((CW > FrameBitsPerRow) || (CFG_FRAME >= MaxFramesPerCol) || (SYNC_STAGES < 1)) begin : g_param_err
      $error("io_bank_cfg_reg: illegal parameter combination");
    end
  endgenerate

  logic [CW-1:0]                       cfg_q, cfg_d;
  logic [NUM_CH-1:0]                   ireg_q, ireg_d;
  logic [NUM_CH-1:0]                   treg_q, treg_d;
  logic [NUM_CH-1:0]                   qprev_q, qprev_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
  logic [NUM_CH-1:0]                   tinv_s, osync_s;

  // Unpack per-channel TINV / OSYNC fields from the config word
  always_comb begin
    tinv_s  = {NUM_CH{1'b0}};
    osync_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      tinv_s[c]  = cfg_q[4*c+3];
      osync_s[c] = cfg_q[4*c+2];
    end
  end

  // Config capture; deliberately outside UserRST so the fabric keeps its modes
  always_comb begin
    if (FrameStrobe[CFG_FRAME]) begin
      cfg_d = FrameData[CW-1:0];
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Config register, no reset
  always_ff @(posedge UserCLK) begin
    cfg_q <= cfg_d;
  end

  // Next state of the user datapath flops
  always_comb begin
    ireg_d  = I;
    treg_d  = T ^ tinv_s;
    qprev_d = Q;
    sync_d  = sync_q;
    sync_d[0] = O_top;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // User datapath flops with synchronous reset
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      ireg_q  <= {NUM_CH{1'b0}};
      treg_q  <= {NUM_CH{1'b1}};
      qprev_q <= {NUM_CH{1'b0}};
      sync_q  <= {(SYNC_STAGES*NUM_CH){1'b0}};
    end else begin
      ireg_q  <= ireg_d;
      treg_q  <= treg_d;
      qprev_q <= qprev_d;
      sync_q  <= sync_d;
    end
  end

  // Pad-side output mux per channel
  always_comb begin
    I_top = {NUM_CH{1'b0}};
    T_top = {NUM_CH{1'b1}};
    for (int c = 0; c < NUM_CH; c++) begin
      case (cfg_q[4*c +: 2])
        2'b00: begin
          I_top[c] = I[c];
          T_top[c] = T[c] ^ tinv_s[c];
        end
        2'b01: begin
          I_top[c] = ireg_q[c];
          T_top[c] = treg_q[c];
        end
        2'b10: begin
          I_top[c] = ireg_q[c];
          T_top[c] = 1'b1;
        end
        2'b11: begin
          I_top[c] = ireg_q[c];
          T_top[c] = 1'b0;
        end
        default: begin
          I_top[c] = ireg_q[c];
          T_top[c] = 1'b1;
        end
      endcase
    end
  end

  assign Q = sync_q[SYNC_STAGES-1];
  assign O = (osync_s & Q) | (~osync_s & O_top);
  assign E = Q & ~qprev_q;

  // Frame buses pass through to the next tile one buffer per bit
  generate
    for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_fd_buf
      assign FrameData_O[b] = FrameData[b];
    end
    for (genvar b = 0; b < MaxFramesPerCol; b++) begin : g_fs_buf
      assign FrameStrobe_O[b] = FrameStrobe[b];
    end
  endgenerate

endmodule

// File: tb/tb_io_bank_cfg_reg.sv
// Randomised bench for io_bank_cfg_reg: two instances (4ch/2-stage, 8ch/3-stage) checked
// against a delay-line reference model of the pad paths and mode table.
module tb_io_bank_cfg_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  i_s, t_s, ot_s;
  logic [31:0] fd;
  logic [19:0] fs;

  logic [3:0]  o_a, q_a, e_a, itop_a, ttop_a;
  logic [31:0] fdo_a;
  logic [19:0] fso_a;
  logic [7:0]  o_b, q_b, e_b, itop_b, ttop_b;
  logic [31:0] fdo_b;
  logic [19:0] fso_b;

  int n_cmp = 0;
  int n_mis = 0;

  io_bank_cfg_reg #(.NUM_CH(4), .FrameBitsPerRow(32), .MaxFramesPerCol(20),
                    .CFG_FRAME(0), .SYNC_STAGES(2)) dut_a (
    .UserCLK(clk), .UserRST(rst), .I(i_s[3:0]), .T(t_s[3:0]), .O(o_a), .Q(q_a), .E(e_a),
    .I_top(itop_a), .T_top(ttop_a), .O_top(ot_s[3:0]),
    .FrameData(fd), .FrameData_O(fdo_a), .FrameStrobe(fs), .FrameStrobe_O(fso_a));

  io_bank_cfg_reg #(.NUM_CH(8), .FrameBitsPerRow(32), .MaxFramesPerCol(20),
                    .CFG_FRAME(5), .SYNC_STAGES(3)) dut_b (
    .UserCLK(clk), .UserRST(rst), .I(i_s), .T(t_s), .O(o_b), .Q(q_b), .E(e_b),
    .I_top(itop_b), .T_top(ttop_b), .O_top(ot_s),
    .FrameData(fd), .FrameData_O(fdo_b), .FrameStrobe(fs), .FrameStrobe_O(fso_b));

  // Reference state: index 0 = dut_a, 1 = dut_b. m_hist[k][j] = O_top sampled j+1 edges ago.
  logic [31:0] m_cfg   [2];
  bit          m_cfg_ok[2];
  logic [7:0]  m_ireg  [2];
  logic [7:0]  m_treg  [2];
  logic [7:0]  m_hist  [2][4];
  bit          m_ok = 1'b0;

  function automatic int nch(input int k);   return (k == 0) ? 4 : 8; endfunction
  function automatic int nsync(input int k); return (k == 0) ? 2 : 3; endfunction
  function automatic int nfrm(input int k);  return (k == 0) ? 0 : 5; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] ei, et, eo, eq, ee, mask;
    logic [3:0] cc;
    chk("frame_data_a", fdo_a, fd);
    chk("frame_strobe_a", {12'h0, fso_a}, {12'h0, fs});
    chk("frame_data_b", fdo_b, fd);
    chk("frame_strobe_b", {12'h0, fso_b}, {12'h0, fs});
    for (int k = 0; k < 2; k++) begin
      mask = (k == 0) ? 8'h0F : 8'hFF;
      eq = m_hist[k][nsync(k)-1] & mask;
      ee = eq & ~m_hist[k][nsync(k)];
      ei = 8'h00; et = 8'h00; eo = 8'h00;
      for (int c = 0; c < nch(k); c++) begin
        cc = m_cfg[k][4*c +: 4];
        case (cc[1:0])
          2'b00:   begin ei[c] = i_s[c];       et[c] = t_s[c] ^ cc[3]; end
          2'b01:   begin ei[c] = m_ireg[k][c]; et[c] = m_treg[k][c];   end
          2'b10:   begin ei[c] = m_ireg[k][c]; et[c] = 1'b1;           end
          default: begin ei[c] = m_ireg[k][c]; et[c] = 1'b0;           end
        endcase
        eo[c] = cc[2] ? eq[c] : ot_s[c];
      end
      if (m_ok) begin
        chk($sformatf("q%0d", k), (k == 0) ? {28'h0, q_a} : {24'h0, q_b}, {24'h0, eq});
        chk($sformatf("e%0d", k), (k == 0) ? {28'h0, e_a} : {24'h0, e_b}, {24'h0, ee});
      end
      if (m_ok && m_cfg_ok[k]) begin
        chk($sformatf("i_top%0d", k), (k == 0) ? {28'h0, itop_a} : {24'h0, itop_b}, {24'h0, ei});
        chk($sformatf("t_top%0d", k), (k == 0) ? {28'h0, ttop_a} : {24'h0, ttop_b}, {24'h0, et});
        chk($sformatf("o%0d", k), (k == 0) ? {28'h0, o_a} : {24'h0, o_b}, {24'h0, eo});
      end
    end
  endtask

  task automatic update_model();
    logic [7:0] tv;
    for (int k = 0; k < 2; k++) begin
      tv = 8'h00;
      for (int c = 0; c < nch(k); c++) tv[c] = m_cfg[k][4*c+3];
      if (rst) begin
        m_ireg[k] = 8'h00;
        m_treg[k] = 8'hFF;
        for (int j = 0; j < 4; j++) m_hist[k][j] = 8'h00;
      end else begin
        m_ireg[k] = i_s;
        m_treg[k] = t_s ^ tv;
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = ot_s;
      end
      if (fs[nfrm(k)]) begin
        m_cfg[k]    = fd;
        m_cfg_ok[k] = 1'b1;
      end
    end
    if (rst) m_ok = 1'b1;
  endtask

  // One cycle: drive on the falling edge, check mid-low-phase, update the model at the rising edge
  task automatic step(input logic r, input logic [19:0] s_fs, input logic [31:0] s_fd,
                      input logic [7:0] s_i, input logic [7:0] s_t, input logic [7:0] s_ot,
                      input logic glitch);
    @(negedge clk);
    rst = r; fs = s_fs; fd = s_fd; i_s = s_i; t_s = s_t; ot_s = s_ot;
    #1;
    check_all();
    if (glitch) begin
      ot_s = ~ot_s;
      #1;
      ot_s = ~ot_s;
    end
    @(posedge clk);
    update_model();
  endtask

  initial begin
    rst = 1'b1; fs = 20'h0; fd = 32'h0; i_s = 8'h0; t_s = 8'h0; ot_s = 8'h0;
    m_cfg_ok[0] = 1'b0;
    m_cfg_ok[1] = 1'b0;
    // Reset and config write together; then strobe low with new data must not change cfg
    step(1'b1, 20'h00021, 32'h0000_F210, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b1, 20'h00000, 32'hDEAD_BEEF, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 20'h00020, 32'h4444_4444, 8'h00, 8'h00, 8'h00, 1'b0);
    // Output-mode step on I with T held low
    step(1'b0, 20'h00000, 32'h1234_5678, 8'hFF, 8'h00, 8'h00, 1'b0);
    step(1'b0, 20'h00000, 32'h1234_5678, 8'hFF, 8'h00, 8'h00, 1'b0);
    // Pad rise, hold for the synchroniser to settle, then sub-cycle glitches
    for (int n = 0; n < 5; n++) step(1'b0, 20'h0, 32'h0, 8'hFF, 8'h00, 8'hFF, 1'b0);
    step(1'b0, 20'h0, 32'h0, 8'hFF, 8'h00, 8'hFF, 1'b1);
    // Reset mid-operation while Q=1 and registered I_top=1, then release with pad low
    step(1'b1, 20'h0, 32'h0, 8'hFF, 8'h00, 8'hFF, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 20'h0, 32'h0, 8'h00, 8'hFF, 8'h00, (n == 2));
    for (int n = 0; n < 4; n++) step(1'b0, 20'h0, 32'h0, 8'h00, 8'h00, 8'h55, 1'b0);
    // Randomised traffic including reconfiguration and occasional reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0,
           32'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 1) == 0) ? ot_s : 8'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
